skinny_sbox_layer_pini1_serial: RTL and testbench
=================================================

# skinny_sbox_layer_pini1_serial

Byte-serial, 2-share SubCells layer for masked SKINNY-128 round logic. It takes a full 128-bit shared state and drives one byte at a time into the 4-cycle non-pipelined PINI-1 S-box core. It holds that byte's shares and fresh 8-bit mask stable for the core's full evaluation window, then captures the result and writes back the substituted shared state. It sits between the round-state register (AddRoundTweakey/MixColumns side) and the rest of the masked round datapath.

## Interface
Parameters:
- NBYTES, 16, number of state bytes processed per layer; must be ≥2.
- CNTW, 4, width of byte index, equal to clog2(NBYTES).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a layer; sampled only in IDLE.
- si1  in  8·NBYTES  state share 1; sampled on the start edge.
- si0  in  8·NBYTES  state share 0; sampled on the start edge.
- rnd  in  8  fresh refreshing mask for one S-box evaluation.
- rnd_valid  in  1  rnd holds fresh bits.
- rnd_ready  out  1  block accepts rnd this cycle.
- so1  out  8·NBYTES  substituted share 1; valid from done until the next start.
- so0  out  8·NBYTES  substituted share 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer completes.

## Operation
- FSM states: IDLE, RND, EVAL, CAPT.
- IDLE:
  - start=1 loads si1/si0 into the working shift registers st1/st0.
  - Clears byte index and eval counter.
  - Next state RND.
- RND:
  - rnd_ready=1.
  - On rnd_valid=1, latches rnd into r_reg and goes to EVAL with cnt=0.
  - Otherwise stays in RND indefinitely; no timeout.
- EVAL:
  - S-box core inputs are st1[7:0], st0[7:0] and r_reg, all register outputs, constant throughout.
  - cnt increments 0→3.
  - At cnt=3, next state is CAPT.
- CAPT:
  - Core output is valid for the whole cycle.
  - On the edge: st1 ← {bo1, st1[8·NBYTES-1:8]}; likewise st0 with bo0.
  - Byte index increments.
  - If the index was NBYTES-1: copy the shifted st1/st0 into so1/so0, set done=1, go to IDLE. Otherwise go to RND.
- After NBYTES captures, every byte k has returned to position k; ordering is preserved.
- Each evaluation consumes exactly one new rnd word. r_reg is never reused across bytes, and there is no internal PRNG.
- st1/st0 are only loaded in IDLE. A new start never disturbs so1/so0 until that layer's done.
- start while busy is ignored and not queued.
- rnd_valid outside RND is ignored; rnd_ready=0.
- Shares are never combined. No XOR of st1 with st0, nor of bo1 with bo0, exists anywhere in the block.
- rst_n low, at any time including mid-layer:
  - Asynchronously forces IDLE.
  - Clears cnt, byte index, r_reg, st1, st0, so1, so0, done, rnd_ready.
  - The partial layer is discarded.
  - The S-box core's internal registers are unreset; they are flushed by the next 4-cycle EVAL.
- Reset values: so1=so0=0, busy=0, done=0, rnd_ready=0.

## Timing
- Start edge = edge 0.
- Per byte: ≥1 RND cycle, 4 EVAL cycles, 1 CAPT cycle; 6 cycles minimum.
- With rnd_valid held high, done rises at edge 6·NBYTES (edge 96 for NBYTES=16). busy is high from edge 0 to that edge.
- Each rnd_valid low cycle during RND adds exactly one cycle.
- done is registered, high for one cycle. start may be asserted in that same cycle and is accepted, because the FSM is in IDLE.
- rnd_ready is a combinational decode of state==RND.
- The rnd handshake completes on any edge where rnd_valid and rnd_ready are both 1.

## Structure
- Shared package/header skinny_pini1_pkg holds:
  - FSM state encodings (2-bit: IDLE=0, RND=1, EVAL=2, CAPT=3).
  - EVAL_CYCLES=4.
  - The byte width constant.
- One sub-module: a single instance of skinny_sbox8_pini1_non_pipelined, with si1/si0/r tied to st1[7:0]/st0[7:0]/r_reg.
- Keep all share registers with the equivalent-register-removal guard, as in the core.

## Test plan
- **Reset:** assert rst_n=0 mid-EVAL of byte 5 → busy=0, done=0, so1=so0=0, rnd_ready=0 immediately. Restart then completes normally in 96 cycles.
- **Zero state:** si0=random M, si1=M (value 0x00 in every byte), rnd_valid=1 → done at edge 96, so1^so0=0x65 in every byte.
- **Mixed bytes:** unmasked bytes 0x00,0x01,0x02,…,0x0F → so1^so0 bytes 0x65,0x4C,0x6A,0x42,… matching the SKINNY S8 table, in the same byte positions.
- **Randomness stall:** hold rnd_valid=0 for 3 cycles before byte 7 → done at edge 99. r_reg is unchanged throughout EVAL; check by probe.
- **Ignored inputs:** pulse start at edge 20 and drive rnd_valid=1 during EVAL → no effect on result or timing. Exactly 16 rnd handshakes are counted.
- **Mask independence:** same unmasked input with two different share splits and rnd streams → identical so1^so0. The individual shares so1 and so0 differ between runs.

Source files
------------

// File: rtl/skinny_pini1_pkg.sv
// Shared definitions for the masked SKINNY-128 byte-serial SubCells layer:
// the FSM encoding, the evaluation window length, and the linear wiring of S8.
package skinny_pini1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RND  = 2'd1,
      ST_EVAL = 2'd2,
      ST_CAPT = 2'd3
   } state_e;

   localparam int BYTE_W      = 8;
   localparam int EVAL_CYCLES = 4;
   localparam int EVAL_CNTW   = 2;

   // Bit permutation that follows each of the first three MIX rounds of S8
   function automatic logic [7:0] sbox_perm(input logic [7:0] x);
      return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
   endfunction

   // Final bit swap (bits 1 and 2) closing the S8 construction
   function automatic logic [7:0] sbox_swap(input logic [7:0] x);
      return {x[7:3], x[1], x[2], x[0]};
   endfunction

endpackage

// File: rtl/skinny_sbox8_pini1_non_pipelined.sv
// Two-share SKINNY S8 as four register stages, one MIX round each; every NOR is
// an HPC2 gadget using its own fresh bit r[2k+g]. Output valid 4 cycles after
// stable inputs. Registers are unreset and flushed by a full evaluation window.
module skinny_sbox8_pini1_non_pipelined
   import skinny_pini1_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] si1,
   input  logic [7:0] si0,
   input  logic [7:0] r,
   output logic [7:0] bo1,
   output logic [7:0] bo0
);

   (* keep = "true" *) logic [7:0] lin0_r [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [7:0] lin1_r [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] p0_r   [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] p1_r   [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] q0_r   [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] q1_r   [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] v0_r   [0:EVAL_CYCLES-1];
   (* keep = "true" *) logic [1:0] v1_r   [0:EVAL_CYCLES-1];

   logic [7:0] x0_s [0:EVAL_CYCLES];
   logic [7:0] x1_s [0:EVAL_CYCLES];

   // Stage registers; NOR(a,b) = ~a & ~b, negation applied to share 0 only
   always_ff @(posedge clk) begin
      for (int k = 0; k < EVAL_CYCLES; k++) begin
         lin0_r[k] <= x0_s[k];
         lin1_r[k] <= x1_s[k];
         for (int g = 0; g < 2; g++) begin
            p0_r[k][g] <= ~x0_s[k][3+4*g] & ~x0_s[k][2+4*g];
            p1_r[k][g] <=  x1_s[k][3+4*g] &  x1_s[k][2+4*g];
            q0_r[k][g] <=  x0_s[k][3+4*g] &  r[2*k+g];
            q1_r[k][g] <= ~x1_s[k][3+4*g] &  r[2*k+g];
            v0_r[k][g] <=  x1_s[k][2+4*g] ^  r[2*k+g];
            v1_r[k][g] <= ~x0_s[k][2+4*g] ^  r[2*k+g];
         end
      end
   end

   // Gadget outputs fold into bits 0/4 of each share, then the linear layer
   always_comb begin
      logic [7:0] m0;
      logic [7:0] m1;
      m0 = 8'h00;
      m1 = 8'h00;
      x0_s[0] = si0;
      x1_s[0] = si1;
      for (int k = 0; k < EVAL_CYCLES; k++) begin
         m0 = lin0_r[k];
         m1 = lin1_r[k];
         for (int g = 0; g < 2; g++) begin
            m0[4*g] = lin0_r[k][4*g] ^ p0_r[k][g] ^ q0_r[k][g]
                      ^ (~lin0_r[k][3+4*g] & v0_r[k][g]);
            m1[4*g] = lin1_r[k][4*g] ^ p1_r[k][g] ^ q1_r[k][g]
                      ^ ( lin1_r[k][3+4*g] & v1_r[k][g]);
         end
         x0_s[k+1] = (k == EVAL_CYCLES - 1) ? sbox_swap(m0) : sbox_perm(m0);
         x1_s[k+1] = (k == EVAL_CYCLES - 1) ? sbox_swap(m1) : sbox_perm(m1);
      end
   end

   assign bo0 = x0_s[EVAL_CYCLES];
   assign bo1 = x1_s[EVAL_CYCLES];

endmodule

// File: rtl/skinny_sbox_layer_pini1_serial.sv
// Byte-serial two-share SubCells layer: rotates the shared state through one
// PINI-1 S-box core, one fresh 8-bit mask per byte, and publishes the result.
module skinny_sbox_layer_pini1_serial
   import skinny_pini1_pkg::*;
#(
   parameter int NBYTES = 16,
   parameter int CNTW   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [8*NBYTES-1:0]      si1,
   input  logic [8*NBYTES-1:0]      si0,
   input  logic [7:0]               rnd,
   input  logic                     rnd_valid,
   output logic                     rnd_ready,
   output logic [8*NBYTES-1:0]      so1,
   output logic [8*NBYTES-1:0]      so0,
   output logic                     busy,
   output logic                     done
);

   localparam int SW = BYTE_W * NBYTES;

   state_e                state_r;
   logic [EVAL_CNTW-1:0]  cnt_r;
   logic [CNTW-1:0]       idx_r;
   logic                  busy_r;
   logic                  done_r;
   (* keep = "true" *) logic [7:0]    rmask_r;
   (* keep = "true" *) logic [SW-1:0] st1_r;
   (* keep = "true" *) logic [SW-1:0] st0_r;
   (* keep = "true" *) logic [SW-1:0] so1_r;
   (* keep = "true" *) logic [SW-1:0] so0_r;

   logic [7:0] bo1_s;
   logic [7:0] bo0_s;

   skinny_sbox8_pini1_non_pipelined u_sbox (
      .clk (clk),
      .si1 (st1_r[BYTE_W-1:0]),
      .si0 (st0_r[BYTE_W-1:0]),
      .r   (rmask_r),
      .bo1 (bo1_s),
      .bo0 (bo0_s)
   );

   // Layer sequencer; byte 0 sits in the low byte and results enter at the top
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {EVAL_CNTW{1'b0}};
         idx_r   <= {CNTW{1'b0}};
         rmask_r <= 8'h00;
         st1_r   <= {SW{1'b0}};
         st0_r   <= {SW{1'b0}};
         so1_r   <= {SW{1'b0}};
         so0_r   <= {SW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  st1_r   <= si1;
                  st0_r   <= si0;
                  cnt_r   <= {EVAL_CNTW{1'b0}};
                  idx_r   <= {CNTW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_RND;
               end
            end
            ST_RND: begin
               if (rnd_valid) begin
                  rmask_r <= rnd;
                  cnt_r   <= {EVAL_CNTW{1'b0}};
                  state_r <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               cnt_r <= cnt_r + EVAL_CNTW'(1);
               if (cnt_r == EVAL_CNTW'(EVAL_CYCLES - 1)) begin
                  state_r <= ST_CAPT;
               end
            end
            ST_CAPT: begin
               st1_r <= {bo1_s, st1_r[SW-1:BYTE_W]};
               st0_r <= {bo0_s, st0_r[SW-1:BYTE_W]};
               idx_r <= idx_r + CNTW'(1);
               if (idx_r == CNTW'(NBYTES - 1)) begin
                  so1_r   <= {bo1_s, st1_r[SW-1:BYTE_W]};
                  so0_r   <= {bo0_s, st0_r[SW-1:BYTE_W]};
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RND;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign rnd_ready = (state_r == ST_RND);
   assign busy      = busy_r;
   assign done      = done_r;
   assign so1       = so1_r;
   assign so0       = so0_r;

endmodule

// File: tb/tb_skinny_sbox_layer_pini1_serial.sv
// Directed bench for the byte-serial masked SubCells layer; expected unmasked
// results come from the published SKINNY-128 S8 table.
module tb_skinny_sbox_layer_pini1_serial;
   import skinny_pini1_pkg::*;

   localparam logic [127:0] U_MIX   = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] EXP_MIX = 128'h7b5b73537a5a75556b43634b426a4c65;
   localparam logic [127:0] U_REV   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] EXP_REV = 128'h654c6a424b63436b55755a7a53735b7b;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] si1;
   logic [127:0] si0;
   logic [7:0]   rnd;
   logic         rnd_valid;
   logic         rnd_ready;
   logic [127:0] so1;
   logic [127:0] so0;
   logic         busy;
   logic         done;

   int           cyc = 0;
   int           hs_total = 0;
   logic [7:0]   hs_rnd = 8'h00;
   int           n_cmp = 0;
   int           n_bad = 0;

   skinny_sbox_layer_pini1_serial #(.NBYTES(16), .CNTW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .si1       (si1),
      .si0       (si0),
      .rnd       (rnd),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .so1       (so1),
      .so0       (so0),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rnd_valid && rnd_ready) begin
         hs_total <= hs_total + 1;
         hs_rnd   <= rnd;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one layer; latency counted in edges after the start edge
   task automatic run_layer(input logic [127:0] u1, input logic [127:0] u0,
                            input int stall_byte, input int pulse_rel, input int abort_rel,
                            output int lat, output int hs, output int rbad,
                            output logic [127:0] mid_x);
      int t0;
      int rel;
      int hs0;
      lat   = -1;
      rbad  = 0;
      mid_x = 128'h0;
      si1   = u1;
      si0   = u0;
      start = 1'b1;
      hs0   = hs_total;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 300; i++) begin
         rel = cyc - t0;
         if (done) begin
            lat = rel;
            break;
         end
         if (rel == abort_rel) begin
            rst_n = 1'b0;
            lat = -2;
            break;
         end
         if (rel == 48) mid_x = so1 ^ so0;
         if (dut.state_r == ST_EVAL && dut.rmask_r !== hs_rnd) rbad++;
         rnd       = 8'($urandom);
         rnd_valid = !(rel >= 6 * stall_byte && rel < 6 * stall_byte + 3);
         start     = (rel + 1 == pulse_rel);
         @(negedge clk);
      end
      start = 1'b0;
      hs = hs_total - hs0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd = 8'h00;
      si1 = 128'h0; si0 = 128'h0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (rnd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
      n_cmp++; if (so1 !== 128'h0) begin n_bad++; $display("FAIL reset_so1: got %h want 0", so1); end
      n_cmp++; if (so0 !== 128'h0) begin n_bad++; $display("FAIL reset_so0: got %h want 0", so0); end
      rst_n = 1'b1;
      rnd_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_state;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      run_layer(m, m, -1, -1, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 96) begin n_bad++; $display("FAIL zero_latency: got %0d want 96", lat); end
      n_cmp++; if (x !== {16{8'h65}}) begin n_bad++; $display("FAIL zero_result: got %h want %h", x, {16{8'h65}}); end
      n_cmp++; if (hs !== 16) begin n_bad++; $display("FAIL zero_handshakes: got %0d want 16", hs); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_mixed_bytes;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      run_layer(U_MIX ^ m, m, -1, -1, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 96) begin n_bad++; $display("FAIL mixed_latency: got %0d want 96", lat); end
      n_cmp++; if (x !== EXP_MIX) begin n_bad++; $display("FAIL mixed_result: got %h want %h", x, EXP_MIX); end
      n_cmp++; if (rbad !== 0) begin n_bad++; $display("FAIL mixed_rmask_stable: got %0d want 0", rbad); end
   endtask

   task automatic test_rnd_stall;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      run_layer(U_MIX ^ m, m, 7, -1, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 99) begin n_bad++; $display("FAIL stall_latency: got %0d want 99", lat); end
      n_cmp++; if (hs !== 16) begin n_bad++; $display("FAIL stall_handshakes: got %0d want 16", hs); end
      n_cmp++; if (rbad !== 0) begin n_bad++; $display("FAIL stall_rmask_stable: got %0d want 0", rbad); end
      n_cmp++; if (x !== EXP_MIX) begin n_bad++; $display("FAIL stall_result: got %h want %h", x, EXP_MIX); end
      @(negedge clk);
   endtask

   task automatic test_ignored_inputs;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      run_layer(U_MIX ^ m, m, -1, 20, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 96) begin n_bad++; $display("FAIL ignored_latency: got %0d want 96", lat); end
      n_cmp++; if (hs !== 16) begin n_bad++; $display("FAIL ignored_handshakes: got %0d want 16", hs); end
      n_cmp++; if (rbad !== 0) begin n_bad++; $display("FAIL ignored_rmask_stable: got %0d want 0", rbad); end
      n_cmp++; if (x !== EXP_MIX) begin n_bad++; $display("FAIL ignored_result: got %h want %h", x, EXP_MIX); end
   endtask

   // Entered while done is high: start in that cycle must be accepted
   task automatic test_back_to_back;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_high: got %b want 1", done); end
      run_layer(U_REV ^ m, m, -1, -1, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 96) begin n_bad++; $display("FAIL b2b_latency: got %0d want 96", lat); end
      n_cmp++; if (mid !== EXP_MIX) begin n_bad++; $display("FAIL b2b_so_held: got %h want %h", mid, EXP_MIX); end
      n_cmp++; if (x !== EXP_REV) begin n_bad++; $display("FAIL b2b_result: got %h want %h", x, EXP_REV); end
      @(negedge clk);
   endtask

   task automatic test_mask_indep;
      logic [127:0] ma, mb, so1_a, so0_a, xa, xb, mid;
      int lat, hs, rbad;
      ma = rand128();
      mb = ~ma ^ rand128();
      run_layer(U_REV ^ ma, ma, -1, -1, -1, lat, hs, rbad, mid);
      so1_a = so1;
      so0_a = so0;
      xa = so1 ^ so0;
      @(negedge clk);
      run_layer(U_REV ^ mb, mb, -1, -1, -1, lat, hs, rbad, mid);
      xb = so1 ^ so0;
      n_cmp++; if (xa !== EXP_REV) begin n_bad++; $display("FAIL mask_a_result: got %h want %h", xa, EXP_REV); end
      n_cmp++; if (xb !== EXP_REV) begin n_bad++; $display("FAIL mask_b_result: got %h want %h", xb, EXP_REV); end
      n_cmp++; if (so1 === so1_a) begin n_bad++; $display("FAIL mask_so1_differs: got %h want value other than %h", so1, so1_a); end
      n_cmp++; if (so0 === so0_a) begin n_bad++; $display("FAIL mask_so0_differs: got %h want value other than %h", so0, so0_a); end
      @(negedge clk);
   endtask

   // Reset lands in the EVAL window of byte 5 while so holds a prior result
   task automatic test_reset_mid;
      logic [127:0] m, x, mid;
      int lat, hs, rbad;
      m = rand128();
      run_layer(U_MIX ^ m, m, -1, -1, 32, lat, hs, rbad, mid);
      #1;
      n_cmp++; if (lat !== -2) begin n_bad++; $display("FAIL midrst_reached: got %0d want -2", lat); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
      n_cmp++; if (rnd_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_rnd_ready: got %b want 0", rnd_ready); end
      n_cmp++; if (so1 !== 128'h0) begin n_bad++; $display("FAIL midrst_so1: got %h want 0", so1); end
      n_cmp++; if (so0 !== 128'h0) begin n_bad++; $display("FAIL midrst_so0: got %h want 0", so0); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m = rand128();
      run_layer(U_MIX ^ m, m, -1, -1, -1, lat, hs, rbad, mid);
      x = so1 ^ so0;
      n_cmp++; if (lat !== 96) begin n_bad++; $display("FAIL restart_latency: got %0d want 96", lat); end
      n_cmp++; if (hs !== 16) begin n_bad++; $display("FAIL restart_handshakes: got %0d want 16", hs); end
      n_cmp++; if (x !== EXP_MIX) begin n_bad++; $display("FAIL restart_result: got %h want %h", x, EXP_MIX); end
   endtask

   initial begin
      test_reset();
      test_zero_state();
      test_mixed_bytes();
      test_rnd_stall();
      test_ignored_inputs();
      test_back_to_back();
      test_mask_indep();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
